// File: rtl/rsa_pkg.sv
// Shared RSA definitions: datapath width, multiplier timing and the
// exponentiation FSM encoding, common to key generation and mod_exp.
package rsa_pkg;

    localparam int WIDTH      = 16;
    localparam int MUL_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        DONE
    } exp_state_t;

endpackage

// File: rtl/mod_mul.sv
// Interleaved shift-add modular multiplier: one multiplier bit per cycle, MSB
// first; done pulses MUL_CYCLES (= WIDTH) cycles after start, product < n.
module mod_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = rsa_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] n_r;
    logic [CNT_W-1:0] cnt;
    logic             active;

    // With r < n and b < n, 2r + b < 3n, so two subtractions always suffice.
    function automatic logic [WIDTH-1:0] mod_step(
        input logic [WIDTH-1:0] acc,
        input logic             bit_i,
        input logic [WIDTH-1:0] mult,
        input logic [WIDTH-1:0] md
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] nn;
        nn = {2'b00, md};
        t  = {1'b0, acc, 1'b0} + (bit_i ? {2'b00, mult} : '0);
        if (t >= nn) t = t - nn;
        if (t >= nn) t = t - nn;
        return t[WIDTH-1:0];
    endfunction

    always_comb begin
        r_nxt = mod_step(r, a_sh[WIDTH-1], b_r, n_r);
    end

    // NOTE: every register here uses <= so all updates see pre-edge values,
    // independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            r       <= '0;
            a_sh    <= '0;
            b_r     <= '0;
            n_r     <= '0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // The launch edge already consumes the top bit of a.
                r      <= mod_step('0, a[WIDTH-1], b, n);
                a_sh   <= {a[WIDTH-2:0], 1'b0};
                b_r    <= b;
                n_r    <= n;
                cnt    <= CNT_W'(WIDTH - 1);
                active <= 1'b1;
            end else if (active) begin
                r    <= r_nxt;
                a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                cnt  <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    active  <= 1'b0;
                    done    <= 1'b1;
                    product <= r_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/mod_exp.sv
// Left-to-right square-and-multiply modular exponentiation. Timing depends on
// the exponent's popcount on purpose: it is the side channel being studied.
module mod_exp
    import rsa_pkg::*;
#(
    parameter int WIDTH = rsa_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             finish
);

    localparam int IDX_W = $clog2(WIDTH);

    exp_state_t       state;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_product;
    logic             mul_done;

    mod_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .n       (mod_r),
        .product (mul_product),
        .done    (mul_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base_r    <= '0;
            exp_r     <= '0;
            mod_r     <= '0;
            acc       <= '0;
            idx       <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            result    <= '0;
            busy      <= 1'b0;
            finish    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r <= base;
                        exp_r  <= exponent;
                        mod_r  <= modulus;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    acc <= WIDTH'(1);
                    idx <= IDX_W'(WIDTH - 1);
                    // Modulus 0 or 1: every residue is 0, skip the loop.
                    if (mod_r[WIDTH-1:1] == '0) begin
                        result <= '0;
                        finish <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        mul_start <= 1'b1;
                        mul_a     <= WIDTH'(1);
                        mul_b     <= WIDTH'(1);
                        state     <= SQR;
                    end
                end
                SQR, MUL: begin
                    mul_start <= 1'b0;
                    if (mul_done) begin
                        acc <= mul_product;
                        if (state == SQR && exp_r[idx]) begin
                            mul_start <= 1'b1;
                            mul_a     <= mul_product;
                            mul_b     <= base_r;
                            state     <= MUL;
                        end else if (idx == '0) begin
                            result <= mul_product;
                            finish <= 1'b1;
                            busy   <= 1'b0;
                            state  <= DONE;
                        end else begin
                            idx       <= idx - 1'b1;
                            mul_start <= 1'b1;
                            mul_a     <= mul_product;
                            mul_b     <= mul_product;
                            state     <= SQR;
                        end
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp.sv
// Directed bench for mod_exp: RSA encrypt/decrypt vectors, latency per
// popcount, degenerate moduli, ignored starts and reset abort/restart.
module tb_mod_exp;
    import rsa_pkg::*;

    localparam int W = WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] base = '0;
    logic [W-1:0] exponent = '0;
    logic [W-1:0] modulus = '0;
    logic [W-1:0] result;
    logic         busy;
    logic         finish;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod_exp #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .result   (result),
        .busy     (busy),
        .finish   (finish)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                                input logic [W-1:0] m);
        longint unsigned r;
        longint unsigned sq;
        if (m <= 1) return '0;
        r  = 1;
        sq = b % m;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * sq) % m;
            sq = (sq * sq) % m;
        end
        return W'(r);
    endfunction

    // Latency is the index of the edge (start edge = 0) at which finish is high.
    task automatic run_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                          input logic [W-1:0] m, input int inj_cycle,
                          output int lat, output logic [W-1:0] res);
        int cycles;
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        lat = -1;
        res = '0;
        cycles = 0;
        while (lat < 0 && cycles < 2000) begin
            @(posedge clk);
            cycles++;
            #1;
            if (cycles == inj_cycle) begin
                base = W'(7); exponent = W'(5); modulus = W'(11); start = 1'b1;
            end else if (cycles == inj_cycle + 1) begin
                start = 1'b0;
            end
            if (finish) begin
                lat = cycles + 1;
                res = result;
                check({tag, "_busy_at_finish"}, 32'(busy), 32'd0);
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            check({tag, "_finish_one_cycle"}, 32'(finish), 32'd0);
            check({tag, "_result_held"}, 32'(result), 32'(res));
        end
    endtask

    initial begin
        int lat;
        int fin_seen;
        logic [W-1:0] res;
        logic [W-1:0] sweep_exp [3];
        int sweep_lat [3];

        sweep_exp[0] = W'(16'h0001); sweep_lat[0] = 291;
        sweep_exp[1] = W'(16'h00FF); sweep_lat[1] = 410;
        sweep_exp[2] = W'(16'hFFFF); sweep_lat[2] = 546;

        repeat (3) @(posedge clk);
        #1;
        check("reset_result", 32'(result), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_finish", 32'(finish), 32'd0);
        rst = 1'b0;

        run_op("enc", W'(89), W'(3), W'(3127), 0, lat, res);
        check("enc_result", 32'(res), 32'd1394);
        check("enc_latency", 32'(lat), 32'd308);

        run_op("dec", W'(1394), W'(2011), W'(3127), 0, lat, res);
        check("dec_result", 32'(res), 32'd89);
        check("dec_latency", 32'(lat), 32'd427);

        run_op("exp0", W'(5), W'(0), W'(3127), 0, lat, res);
        check("exp0_result", 32'(res), 32'd1);
        check("exp0_latency", 32'(lat), 32'd274);

        run_op("mod1", W'(0), W'(3), W'(1), 0, lat, res);
        check("mod1_result", 32'(res), 32'd0);
        check("mod1_latency", 32'(lat), 32'd2);

        run_op("mod0", W'(9), W'(3), W'(0), 0, lat, res);
        check("mod0_result", 32'(res), 32'd0);
        check("mod0_latency", 32'(lat), 32'd2);

        run_op("inject", W'(1394), W'(2011), W'(3127), 50, lat, res);
        check("inject_result", 32'(res), 32'd89);
        check("inject_latency", 32'(lat), 32'd427);

        // Abort a decrypt with rst sampled at edge 100, then restart at once.
        @(negedge clk);
        base = W'(1394); exponent = W'(2011); modulus = W'(3127); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        fin_seen = 0;
        for (int c = 1; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (finish) fin_seen++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_no_finish", 32'(fin_seen), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_finish", 32'(finish), 32'd0);
        run_op("restart", W'(89), W'(3), W'(3127), 0, lat, res);
        check("restart_result", 32'(res), 32'd1394);
        check("restart_latency", 32'(lat), 32'd308);

        // rst wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        base = W'(89); exponent = W'(3); modulus = W'(3127);
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        check("rst_prio_result", 32'(result), 32'd0);

        for (int i = 0; i < 3; i++) begin
            run_op($sformatf("sweep%0d", i), W'(89), sweep_exp[i], W'(3127), 0, lat, res);
            check($sformatf("sweep%0d_result", i), 32'(res),
                  32'(ref_modexp(W'(89), sweep_exp[i], W'(3127))));
            check($sformatf("sweep%0d_latency", i), 32'(lat), 32'(sweep_lat[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_exp.md
MOD_EXP -- requirements
Module: mod_exp

Interface
REQ-001 Parameter WIDTH, default 16: width of the operand, exponent, modulus and result.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  single-cycle request; operands are sampled on the same edge.
REQ-005 base  input  WIDTH  message or ciphertext; base < modulus is required.
REQ-006 exponent  input  WIDTH  public or private exponent (e or d from the key generator).
REQ-007 modulus  input  WIDTH  RSA modulus n from the key generator.
REQ-008 result  output  WIDTH  base^exponent mod modulus; held stable until the next accepted start.
REQ-009 busy  output  1  high from the cycle after start is accepted until finish.
REQ-010 finish  output  1  one-cycle pulse; result is valid in that cycle.

Function
REQ-011 States SHALL be IDLE, LOAD, SQR, MUL, DONE; IDLE is the only state in which start is accepted.
REQ-012 A start with busy high SHALL be ignored, with no effect on state, operands or result.
REQ-013 LOAD SHALL latch base, exponent and modulus, set acc=1 and bit index=WIDTH-1, and SHALL take 1 cycle.
REQ-014 Exponentiation SHALL be left-to-right square-and-multiply over all WIDTH exponent bits, MSB first, with no skipping of leading zeros.
REQ-015 Per bit: SQR computes acc=acc*acc mod n; if the bit is 1, MUL then computes acc=acc*base mod n; then the index decrements.
REQ-016 Each modular multiply SHALL occupy exactly 17 cycles: 1 launch cycle plus 16 iteration cycles.
REQ-017 After bit 0 is processed the FSM SHALL enter DONE, load result, pulse finish for 1 cycle and return to IDLE.
REQ-018 Latency SHALL be exactly 2 + 17*(WIDTH + popcount(exponent)) cycles, counted from the start-sampling edge to the edge at which finish is high; the data-dependent timing is intentional, because it is the side-channel under study.
REQ-019 The multiplier SHALL use interleaved shift-add reduction: r = 2r + a_bit*b, followed by up to two conditional subtractions of n.
REQ-020 The multiplier SHALL hold its intermediate in WIDTH+2 bits, and its result SHALL always be < n.
REQ-021 modulus 0 or 1: the block SHALL skip exponentiation and go LOAD -> DONE with result=0, giving finish 2 cycles after start.
REQ-022 exponent=0 with modulus >= 2: result SHALL be 1, with the full 17*WIDTH+2 latency.
REQ-023 base >= modulus: result SHALL be unspecified, but latency and handshake SHALL be as specified.
REQ-024 busy and finish SHALL never be high in the same cycle.

Reset
REQ-025 With rst high at an edge, the block SHALL go to IDLE with result=0, busy=0, finish=0, acc=0 and the multiplier idle.
REQ-026 Reset mid-operation SHALL abort without a finish pulse; a start on the first cycle after rst falls SHALL be accepted.
REQ-027 rst SHALL take priority over start when both are high.

Structure
REQ-028 Shared package rsa_pkg SHALL hold WIDTH, MUL_CYCLES=16 and the FSM state enum, so they are shared with the key-generation block.
REQ-029 The modular multiplier SHALL be a sub-module mod_mul, with ports clk, rst, start, a, b, n, product, done.
REQ-030 mod_mul done SHALL pulse exactly 16 cycles after its start, and mod_exp SHALL contain no other arithmetic instance.

Verification
REQ-031 Encrypt: base=89, exponent=3, modulus=3127 -> result=1394, finish after 2+17*18=308 cycles.
REQ-032 Decrypt: base=1394, exponent=2011, modulus=3127 -> result=89, finish after 2+17*25=427 cycles.
REQ-033 exponent=0, base=5, modulus=3127 -> result=1 after 274 cycles; modulus=1 -> result=0 after 2 cycles.
REQ-034 A start pulse with new operands mid-run of case REQ-032 -> ignored; the run completes with result 89 at cycle 427.
REQ-035 rst asserted at cycle 100 of case REQ-032 -> no finish, result=0, busy=0; an immediate restart of REQ-031 -> 1394 after 308 cycles.
REQ-036 Timing sweep: exponents 0x0001, 0x00FF and 0xFFFF with modulus 3127 -> latencies 291, 410 and 546 cycles, and results match a reference model.
